stack_cmd_master: RTL
=====================

Name: stack_cmd_master

Overview:
- Command-side master for the 8-bit, 15-entry LIFO stack block.
- Accepts push/pop commands over a valid/ready interface and drives the stack's registered push/pop/data_in strobes.
- Waits out the stack's pop read latency and returns one response per command.
- Tracks occupancy locally, so overflow and underflow are rejected before any strobe reaches the stack; the stack's own error output is not used.

Parameters:
- DATA_W, 8: command/stack data width.
- DEPTH, 15: usable stack entries; the stack pointer runs 15 (empty) down to 0, and a push at 0 is rejected.
- CNT_W, 4: occupancy counter width; must hold 0..DEPTH.
- POP_LATENCY, 2: cycles from the stk_pop cycle until stk_data_out is valid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; also wired to the stack's reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_op  in  1  0 = push, 1 = pop
- cmd_data  in  DATA_W  push data (ignored for pop)
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  DATA_W  popped data; 0 for push and error responses
- rsp_err  out  1  command rejected (overflow or underflow)
- level  out  CNT_W  current occupancy
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_data_in  out  DATA_W  to stack data_in
- stk_data_out  in  DATA_W  from stack data_out

Behaviour:
- Reset values:
  - state = IDLE, level = 0.
  - cmd_ready = 1 from the first cycle after reset deasserts; 0 while reset is high.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0.
  - stk_push = 0, stk_pop = 0, stk_data_in = 0.
- Strobe timing:
  - stk_push and stk_pop are decoded from the state register.
  - Each is high for exactly one cycle per command and never both high together.
- States:
  - IDLE: cmd_ready = 1. On accept, choose the next state:
    - push with level == DEPTH -> ERR
    - pop with level == 0 -> ERR
    - push otherwise -> PUSH
    - pop otherwise -> POP
  - PUSH: stk_push = 1; stk_data_in = cmd_data captured at the accept edge. Next -> RESP.
  - POP: stk_pop = 1. Next -> WAIT.
  - WAIT: lasts POP_LATENCY cycles. On the final WAIT cycle's edge, capture stk_data_out into rsp_data. Next -> RESP.
  - ERR: rsp_valid = 1, rsp_err = 1, rsp_data = 0. No strobes; level unchanged. Next -> IDLE.
  - RESP: rsp_valid = 1, rsp_err = 0. Next -> IDLE.
- cmd_ready = 0 in every state except IDLE.
- Level updates at the accept edge: +1 for a legal push, -1 for a legal pop, unchanged on error.
- Latency, with accept at edge ending cycle A:
  - error: rsp_valid in A+1
  - push: stk_push in A+1, rsp_valid in A+2
  - pop: stk_pop in A+1, stk_data_out valid in A+3 (POP_LATENCY = 2), rsp_valid in A+4
- Throughput:
  - Minimum command spacing is 2 cycles (error), 3 (push) and 5 (pop); the mandatory IDLE cycle between commands is included.
  - This spacing guarantees a push's stack write lands before any following pop is sampled by the stack.
- Ordering: LIFO data order is provided entirely by the stack; this block reorders nothing.
- Reset mid-operation, in any state:
  - Next state IDLE, level = 0, all strobes and responses low.
  - An in-flight command gets no response.
  - stk_push and stk_pop must be 0 in the last reset cycle, so the stack's input registers are clean.
- Wrap-around: level never exceeds DEPTH or goes below 0. Rejected commands do not touch the stack, so its pointer never wraps.
- cmd_valid while not ready is ignored; cmd_op and cmd_data must hold until accept, per the valid/ready rule.

Test Plan:
- Push 0xA5, then pop -> push rsp_valid at A+2 with rsp_err = 0; pop rsp_valid at A+4 with rsp_data = 0xA5; level goes 0 -> 1 -> 0.
- Push 0x01, 0x02, 0x03, then pop x3 -> rsp_data 0x03, 0x02, 0x01; level ends at 0.
- Push 0x00..0x0E (15 pushes), then push 0xFF -> 16th response rsp_err = 1 one cycle after accept; no stk_push; level stays 15. Pop then returns 0x0E.
- Pop at reset-empty -> rsp_err = 1, rsp_data = 0, stk_pop never asserted, level stays 0.
- Push 0x11, then pop; assert reset during the first WAIT cycle -> no rsp_valid, level = 0, cmd_ready high the cycle after reset drops; a following pop returns rsp_err = 1.
- cmd_valid held high with back-to-back pushes -> accepts spaced exactly 3 cycles apart; stk_push never high in adjacent cycles.

Source files
------------

// File: rtl/stack_cmd_master.sv
// stack_cmd_master
// Command-side master for an 8-bit, 15-entry LIFO stack block.
// Accepts push/pop commands over valid/ready and drives the stack's push/pop
// strobes. After a pop it waits out the stack's read latency, then returns
// exactly one response per command. Occupancy is tracked locally, so overflow
// and underflow are rejected here and never reach the stack.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset (shared with stack)
//   cmd_valid/ready  command handshake; accept when both high at a clk edge
//   cmd_op           0 = push, 1 = pop
//   cmd_data         push data
//   rsp_valid        one-cycle response pulse (no backpressure)
//   rsp_data         popped data; 0 for push and error responses
//   rsp_err          command rejected (overflow / underflow)
//   level            current occupancy
//   stk_push/stk_pop one-cycle strobes to the stack
//   stk_data_in      data to the stack
//   stk_data_out     data from the stack, valid POP_LATENCY cycles after stk_pop
module stack_cmd_master #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 15,
    parameter int CNT_W       = 4,
    parameter int POP_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  level,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic [DATA_W-1:0] stk_data_out
);

    localparam int WAIT_W = (POP_LATENCY > 1) ? $clog2(POP_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  LEVEL_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LEVEL_ONE  = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(POP_LATENCY - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        WAIT,
        ERR,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_data;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              accept;

    assign wait_done = (wait_cnt == WAIT_LAST);
    // Ready is only ever high in IDLE and is gated by reset below, so this is
    // the real handshake condition.
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All outputs are decoded from the state register. Reset forces them low
    // combinationally as well, so no strobe can reach the stack during the
    // last reset cycle even if the state register still holds PUSH or POP.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!cmd_op && (level == LEVEL_FULL)) begin
                        state_next = ERR;
                    end else if (cmd_op && (level == '0)) begin
                        state_next = ERR;
                    end else if (!cmd_op) begin
                        state_next = PUSH;
                    end else begin
                        state_next = POP;
                    end
                end
            end
            PUSH: begin
                stk_push    = 1'b1;
                stk_data_in = push_data;
                state_next  = RESP;
            end
            POP: begin
                stk_pop    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_done) begin
                    state_next = RESP;
                end
            end
            ERR: begin
                rsp_valid  = 1'b1;
                rsp_err    = 1'b1;
                state_next = IDLE;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_data   = pop_data;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (reset) begin
            cmd_ready   = 1'b0;
            stk_push    = 1'b0;
            stk_pop     = 1'b0;
            stk_data_in = '0;
            rsp_valid   = 1'b0;
            rsp_err     = 1'b0;
            rsp_data    = '0;
        end
    end

    // Occupancy moves at the accept edge so the IDLE decision for the next
    // command already sees it. pop_data is cleared on every accept so push
    // responses report zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= '0;
            push_data <= '0;
            pop_data  <= '0;
            wait_cnt  <= '0;
        end else begin
            if (accept) begin
                push_data <= cmd_data;
                pop_data  <= '0;
                if (!cmd_op && (level != LEVEL_FULL)) begin
                    level <= level + LEVEL_ONE;
                end else if (cmd_op && (level != '0)) begin
                    level <= level - LEVEL_ONE;
                end
            end
            if (state == POP) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WAIT_ONE;
                if (wait_done) begin
                    pop_data <= stk_data_out;
                end
            end
        end
    end

endmodule
